// File: rtl/p2s_pkg.sv
// p2s_pkg: shared definitions for the parallel-to-serial arbiter slice.
//   state_t          : arbiter FSM states (IDLE, SHIFT)
//   P2S_NREQ_DEF     : default number of requesters
//   P2S_WIDTH_DEF    : default word width per requester
//   frame_len()      : serial frame length for a given word width
//   rr_index()       : round-robin candidate index (base + off) mod n
// Optional feature macro: P2S_ARB_PARITY_EN (adds one even-parity bit per frame).
package p2s_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned P2S_NREQ_DEF  = 4;
  localparam int unsigned P2S_WIDTH_DEF = 4;

  function automatic int unsigned frame_len(input int unsigned width);
`ifdef P2S_ARB_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  function automatic int unsigned rr_index(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/p2s_shifter.sv
// p2s_shifter: frame shift register, bit counter and optional parity bit.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : capture load_data and restart the bit counter
//   load_data    : word to serialise (MSB first)
//   shift_en     : advance one bit (frame in flight)
//   sdata        : current serial bit
//   first        : counter is on the first bit of the frame
//   last         : counter is on the last bit of the frame
// Optional feature macro: P2S_ARB_PARITY_EN (frame gets a trailing even-parity bit).
module p2s_shifter
  import p2s_pkg::*;
#(
  parameter int unsigned WIDTH = P2S_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             sdata,
  output logic             first,
  output logic             last
);

  localparam int unsigned FL = frame_len(WIDTH);
  localparam int unsigned CW = $clog2(FL);

  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;

  assign first = (cnt == '0);
  assign last  = (cnt == CW'(FL - 1));

  // The counter wraps to 0 on the last bit so an idle shifter always
  // sits at count 0, ready for the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= load_data;
      cnt  <= '0;
    end else if (shift_en) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
      cnt  <= last ? '0 : cnt + 1'b1;
    end
  end

`ifdef P2S_ARB_PARITY_EN
  logic par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par <= 1'b0;
    end else if (load) begin
      par <= ^load_data;
    end
  end

  assign sdata = (cnt == CW'(WIDTH)) ? par : sreg[WIDTH-1];
`else
  assign sdata = sreg[WIDTH-1];
`endif

endmodule

// File: rtl/p2s_arbiter.sv
// p2s_arbiter: round-robin arbiter feeding a single serial output.
// Ports:
//   clk        : clock, all state on rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : [NREQ] per-requester word-available flags
//   req_data   : [NREQ*WIDTH] packed words, requester i at [i*WIDTH +: WIDTH]
//   req_ready  : [NREQ] one-hot accept strobe (combinational)
//   dout       : serial data, MSB first
//   valid_out  : high during the first bit of each frame
//   busy       : high while a frame is shifting
//   grant_id   : index of the requester whose frame is on dout
// Optional feature macro: P2S_ARB_PARITY_EN (even-parity bit after bit 0).
module p2s_arbiter
  import p2s_pkg::*;
#(
  parameter int unsigned NREQ  = P2S_NREQ_DEF,
  parameter int unsigned WIDTH = P2S_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    dout,
  output logic                    valid_out,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int unsigned IW = $clog2(NREQ);

  state_t           state, state_nxt;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    gnt_idx;
  logic [IW-1:0]    cand;
  logic             gnt_any;
  logic             window;
  logic             hs;
  logic [WIDTH-1:0] gnt_word;
  logic             sdata;
  logic             sh_first;
  logic             sh_last;

  assign window = (state == IDLE) || sh_last;

  // Search from ptr+1 upward with wrap; first valid requester wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = IW'(rr_index(32'(ptr), off, NREQ));
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // rst_n gates the strobe so nothing is accepted while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && window && gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign hs = |req_ready;

  always_comb begin
    gnt_word = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        gnt_word = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= IW'(NREQ - 1);
      grant_id <= '0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        ptr      <= gnt_idx;
        grant_id <= gnt_idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    dout      = 1'b0;
    valid_out = 1'b0;
    case (state)
      IDLE: begin
        if (hs) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy      = 1'b1;
        dout      = sdata;
        valid_out = sh_first;
        if (sh_last && !hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  p2s_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (hs),
    .load_data (gnt_word),
    .shift_en  (state == SHIFT),
    .sdata     (sdata),
    .first     (sh_first),
    .last      (sh_last)
  );

endmodule

// File: tb/tb_p2s_arbiter.sv
module tb_p2s_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
`ifdef P2S_ARB_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  dout;
  logic                  valid_out;
  logic                  busy;
  logic [1:0]            grant_id;

  int n_chk  = 0;
  int n_fail = 0;

  p2s_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .dout      (dout),
    .valid_out (valid_out),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [WIDTH-1:0] w, input int b);
    if (b < WIDTH) return w[WIDTH-1-b];
    return ^w;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_vout"}, valid_out, 0);
  endtask

  // Runs one frame starting at the handshake edge. New valid/data values are
  // applied just after the first bit is checked; exp_rdy is checked on the last bit.
  task automatic frame(input int id, input logic [WIDTH-1:0] word,
                       input logic [NREQ-1:0] nv, input logic [NREQ*WIDTH-1:0] nd,
                       input logic [NREQ-1:0] exp_rdy);
    for (int b = 0; b < FL; b++) begin
      @(posedge clk); #1;
      if (b == 0) begin
        chk("first_vout", valid_out, 1);
        chk("grant_id", grant_id, id);
        req_valid = nv;
        req_data  = nd;
        #1;
      end else begin
        chk("later_vout", valid_out, 0);
      end
      chk("busy", busy, 1);
      chk($sformatf("dout_g%0d_b%0d", id, b), dout, exp_bit(word, b));
      if (b == FL - 1) chk("last_ready", req_ready, exp_rdy);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
  endtask

  logic [NREQ*WIDTH-1:0] d4;

  initial begin
    // Reset state, with a request pending that must not be acknowledged.
    rst_n     = 1'b0;
    req_valid = 4'b0001;
    req_data  = {4'h0, 4'h0, 4'h0, 4'b1011};
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_gid", grant_id, 0);
    chk_idle("rst");
    @(posedge clk); #1;
    chk_idle("rst_hold");
    rst_n = 1'b1;
    #1;

    // Single frame from requester 0.
    chk("single_ready", req_ready, 4'b0001);
    frame(0, 4'b1011, 4'b0000, req_data, 4'b0000);
    @(posedge clk); #1;
    chk_idle("single_end");
    chk("single_gid_hold", grant_id, 0);

    // All four valid: order 0,1,2,3,0 without gaps.
    do_reset();
    d4 = {4'h0, 4'hF, 4'h5, 4'hA};
    req_data  = d4;
    req_valid = 4'b1111;
    #1;
    chk("all_ready0", req_ready, 4'b0001);
    frame(0, 4'hA, 4'b1111, d4, 4'b0010);
    frame(1, 4'h5, 4'b1111, d4, 4'b0100);
    frame(2, 4'hF, 4'b1111, d4, 4'b1000);
    frame(3, 4'h0, 4'b1111, d4, 4'b0001);
    frame(0, 4'hA, 4'b0000, d4, 4'b0000);
    @(posedge clk); #1;
    chk_idle("all_end");

    // After grant 2 only 1 and 3 valid: 3 then 1 (wrap).
    do_reset();
    d4 = {4'h3, 4'hC, 4'h9, 4'h6};
    req_data  = d4;
    req_valid = 4'b0100;
    #1;
    chk("wrap_ready0", req_ready, 4'b0100);
    frame(2, 4'hC, 4'b1010, d4, 4'b1000);
    frame(3, 4'h3, 4'b1010, d4, 4'b0010);
    frame(1, 4'h9, 4'b0000, d4, 4'b0000);
    @(posedge clk); #1;
    chk_idle("wrap_end");

    // Reset on the 2nd bit of a frame from requester 2.
    do_reset();
    req_data  = {4'h0, 4'hF, 4'h0, 4'h9};
    req_valid = 4'b0100;
    #1;
    chk("abort_ready", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    chk("abort_b0", dout, 1);
    @(posedge clk); #1;
    chk("abort_busy_pre", busy, 1);
    chk("abort_gid_pre", grant_id, 2);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_dout", dout, 0);
    chk("abort_vout", valid_out, 0);
    chk("abort_gid", grant_id, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("abort_noresume");
    req_valid = 4'b1101;
    #1;
    chk("abort_ptr", req_ready, 4'b0001);
    frame(0, 4'h9, 4'b0000, req_data, 4'b0000);
    @(posedge clk); #1;
    chk_idle("abort_end");

    // Data of the granted requester changed mid-frame.
    do_reset();
    req_data  = {4'h0, 4'h0, 4'h0, 4'b1011};
    req_valid = 4'b0001;
    #1;
    chk("hold_ready", req_ready, 4'b0001);
    frame(0, 4'b1011, 4'b0000, {4'h0, 4'h0, 4'h0, 4'b0100}, 4'b0000);
    @(posedge clk); #1;
    chk_idle("hold_end");

`ifdef P2S_ARB_PARITY_EN
    do_reset();
    req_data  = {4'h0, 4'h0, 4'h0, 4'b0111};
    req_valid = 4'b0001;
    #1;
    frame(0, 4'b0111, 4'b0000, req_data, 4'b0000);
    chk("par_0111", dout, 1);
    @(posedge clk); #1;
    req_data  = {4'h0, 4'h0, 4'h0, 4'b0110};
    req_valid = 4'b0001;
    #1;
    frame(0, 4'b0110, 4'b0000, req_data, 4'b0000);
    chk("par_0110", dout, 0);
    @(posedge clk); #1;
    chk_idle("par_end");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
